current_steering_dac: RTL and testbench

// - Behavioural real-valued model of a 7-bit binary + 17-segment thermometer current-steering DAC core.
// - Steers bias-generator unit currents to the Iout or Ioutb output node, plus a 5-bit calibration current Ical.
// - Provides power-down and supply-window gating, and a 2-bit analogue test-bus mux.
// - Sits between the bias generator and the DAC output stage.

---
 rtl/current_steering_dac_pkg.sv | 41 ++++
 rtl/current_steering_dac_if.sv | 22 ++
 rtl/current_steering_dac_steer_cell.sv | 15 +
 rtl/current_steering_dac.sv | 108 ++++++++++
 tb/tb_current_steering_dac.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/current_steering_dac_pkg.sv
// Shared constants, types and the supply-window helper for the current-steering DAC core model.
package current_steering_pkg;

  localparam int N_THERM = 17;
  localparam int N_BIN   = 6;
  localparam int N_CELLS = N_THERM + N_BIN + 1;
  localparam int DIN_W   = N_BIN + 1;
  localparam int ICAL_W  = 5;

  localparam real ICAL_DIV   = 640.0;
  localparam real V18_NOM    = 1.8;
  localparam real V08_NOM    = 0.8;
  localparam real V18_TOL    = 0.05;
  localparam real V08_TOL    = 0.05;
  // Slack so that a supply sitting exactly on a bound (e.g. 1.71 V) counts as inside
  // despite floating-point rounding of nom*(1-tol).
  localparam real WINDOW_EPS = 1.0e-9;

  typedef enum logic [1:0] {
    ATB_GND    = 2'b00,
    ATB_VCAS   = 2'b01,
    ATB_SUPPLY = 2'b10,
    ATB_MIXED  = 2'b11
  } atb_sel_e;

  typedef struct packed {
    logic                pdb;
    logic                atest_ena;
    atb_sel_e            atb_sel;
    logic [DIN_W-1:0]    datain;
    logic [DIN_W-1:0]    datainb;
    logic [N_THERM-1:0]  datatherm;
    logic [N_THERM-1:0]  datathermb;
    logic [ICAL_W-1:0]   dataical;
  } codes_t;

  function automatic logic in_window(real v, real nom, real tol);
    return (v >= nom * (1.0 - tol) - WINDOW_EPS) && (v <= nom * (1.0 + tol) + WINDOW_EPS);
  endfunction

endpackage

// File: rtl/current_steering_dac_if.sv
// Digital code bus into the DAC core: control bits, steering codes and calibration code.
interface current_steering_dac_if;
  import current_steering_pkg::*;

  logic                pdb;
  logic                atest_ena;
  logic [1:0]          atb_ena;
  logic [DIN_W-1:0]    datain;
  logic [DIN_W-1:0]    datainb;
  logic [N_THERM-1:0]  datatherm;
  logic [N_THERM-1:0]  datathermb;
  logic [ICAL_W-1:0]   dataical;

  modport master (
    output pdb, atest_ena, atb_ena, datain, datainb, datatherm, datathermb, dataical
  );

  modport slave (
    input pdb, atest_ena, atb_ena, datain, datainb, datatherm, datathermb, dataical
  );

endinterface

// File: rtl/current_steering_dac_steer_cell.sv
// One current-steering switch pair: routes a unit current to the true or complement node.
module steer_cell (
  input  real  I,
  input  logic d,
  input  logic db,
  input  logic en,
  output real  i_p,
  output real  i_n
);

  // A pair with d == db models both switches open or both shorted: the current is lost.
  assign i_p = (en && d && !db) ? I : 0.0;
  assign i_n = (en && !d && db) ? I : 0.0;

endmodule

// File: rtl/current_steering_dac.sv
// 7-bit binary + 17-segment thermometer current-steering DAC core with calibration current,
// power-down/supply-window gating and a 2-bit analogue test-bus mux.
module current_steering_dac
  import current_steering_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  real                         iref_500ua,
  current_steering_dac_if.slave       code_if,
  input  real                         vddana_1p8,
  input  real                         vddana_0p8,
  input  real                         vssana,
  input  real                         Vcas,
  input  real                         Iout_them [N_THERM],
  input  real                         Iout_binary [N_BIN],
  input  real                         Iout_binary_0_red,
  output real                         Iout,
  output real                         Ioutb,
  output real                         Ical,
  output real                         atb0,
  output real                         atb1
);

  codes_t codes_d;
  codes_t codes_q;
  logic   active;

  real                cell_i [N_CELLS];
  real                cell_p [N_CELLS];
  real                cell_n [N_CELLS];
  logic [N_CELLS-1:0] cell_d;
  logic [N_CELLS-1:0] cell_db;

  always_comb begin
    codes_d            = '0;
    codes_d.pdb        = code_if.pdb;
    codes_d.atest_ena  = code_if.atest_ena;
    codes_d.atb_sel    = atb_sel_e'(code_if.atb_ena);
    codes_d.datain     = code_if.datain;
    codes_d.datainb    = code_if.datainb;
    codes_d.datatherm  = code_if.datatherm;
    codes_d.datathermb = code_if.datathermb;
    codes_d.dataical   = code_if.dataical;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // pre-edge value of its inputs; the async reset clears all codes, which turns the core off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) codes_q <= '0;
    else        codes_q <= codes_d;
  end

  assign active = codes_q.pdb
               && in_window(vddana_1p8, V18_NOM, V18_TOL)
               && in_window(vddana_0p8, V08_NOM, V08_TOL);

  // Cell order: thermometer 0..16, binary 0..5, then the redundant LSB driven by datain[6].
  always_comb begin
    for (int i = 0; i < N_CELLS; i++) cell_i[i] = 0.0;
    for (int i = 0; i < N_THERM; i++) cell_i[i] = Iout_them[i];
    for (int k = 0; k < N_BIN; k++)   cell_i[N_THERM+k] = Iout_binary[k];
    cell_i[N_CELLS-1] = Iout_binary_0_red;
  end

  assign cell_d  = {codes_q.datain,  codes_q.datatherm};
  assign cell_db = {codes_q.datainb, codes_q.datathermb};

  for (genvar g = 0; g < N_CELLS; g++) begin : g_cell
    steer_cell u_cell (
      .I   (cell_i[g]),
      .d   (cell_d[g]),
      .db  (cell_db[g]),
      .en  (active),
      .i_p (cell_p[g]),
      .i_n (cell_n[g])
    );
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    real sum_p;
    real sum_n;
    sum_p = 0.0;
    sum_n = 0.0;
    for (int g = 0; g < N_CELLS; g++) begin
      sum_p = sum_p + cell_p[g];
      sum_n = sum_n + cell_n[g];
    end
    Iout  = sum_p;
    Ioutb = sum_n;
    Ical  = active ? real'(codes_q.dataical) * iref_500ua / ICAL_DIV : 0.0;
  end

  always_comb begin
    atb0 = vssana;
    atb1 = vssana;
    if (codes_q.atest_ena) begin
      unique case (codes_q.atb_sel)
        ATB_GND:    begin atb0 = vssana;     atb1 = vssana;           end
        ATB_VCAS:   begin atb0 = Vcas;       atb1 = vssana;           end
        ATB_SUPPLY: begin atb0 = vddana_0p8; atb1 = vddana_1p8;       end
        ATB_MIXED:  begin atb0 = Vcas;       atb1 = vddana_0p8 / 2.0; end
        default:    begin atb0 = vssana;     atb1 = vssana;           end
      endcase
    end
  end

endmodule

// File: tb/tb_current_steering_dac.sv
// Randomised scoreboard bench for current_steering_dac against a plain-arithmetic reference model.
module tb_current_steering_dac;

  logic clk = 1'b0;
  logic rst_n;
  real  iref, vdd18, vdd08, vss, vcas;
  real  ith [17];
  real  ibin [6];
  real  ired;
  real  iout, ioutb, ical, atb0, atb1;

  current_steering_dac_if dac_if ();

  current_steering_dac dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .iref_500ua        (iref),
    .code_if           (dac_if),
    .vddana_1p8        (vdd18),
    .vddana_0p8        (vdd08),
    .vssana            (vss),
    .Vcas              (vcas),
    .Iout_them         (ith),
    .Iout_binary       (ibin),
    .Iout_binary_0_red (ired),
    .Iout              (iout),
    .Ioutb             (ioutb),
    .Ical              (ical),
    .atb0              (atb0),
    .atb1              (atb1)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    real   iout;
    real   ioutb;
    real   ical;
    real   atb0;
    real   atb1;
  } exp_t;

  exp_t sb [$];
  int   checks = 0;
  int   errors = 0;

  function automatic bit close(real a, real b);
    real d, m;
    d = (a > b) ? a - b : b - a;
    m = (b < 0.0) ? -b : b;
    return d <= 1.0e-12 + 1.0e-9 * m;
  endfunction

  task automatic check(input string name, input real act, input real exp);
    checks++;
    if (!close(act, exp)) begin
      errors++;
      $display("FAIL %s: got %g, expected %g", name, act, exp);
    end
  endtask

  // Reference: the supply window is written out as absolute voltages, currents are summed
  // per cell from the pair rule, and nothing is gated or registered beyond the one-cycle capture.
  function automatic exp_t model();
    exp_t e;
    bit   on;
    real  to_p, to_n;
    e.name = "";
    e.iout = 0.0; e.ioutb = 0.0; e.ical = 0.0; e.atb0 = 0.0; e.atb1 = 0.0;
    if (rst_n !== 1'b1) return e;
    on = dac_if.pdb && (vdd18 >= 1.71 - 1e-9) && (vdd18 <= 1.89 + 1e-9)
                    && (vdd08 >= 0.76 - 1e-9) && (vdd08 <= 0.84 + 1e-9);
    to_p = 0.0;
    to_n = 0.0;
    for (int i = 0; i < 17; i++) begin
      if (dac_if.datatherm[i] && !dac_if.datathermb[i]) to_p += ith[i];
      if (!dac_if.datatherm[i] && dac_if.datathermb[i]) to_n += ith[i];
    end
    for (int k = 0; k < 6; k++) begin
      if (dac_if.datain[k] && !dac_if.datainb[k]) to_p += ibin[k];
      if (!dac_if.datain[k] && dac_if.datainb[k]) to_n += ibin[k];
    end
    if (dac_if.datain[6] && !dac_if.datainb[6]) to_p += ired;
    if (!dac_if.datain[6] && dac_if.datainb[6]) to_n += ired;
    if (on) begin
      e.iout  = to_p;
      e.ioutb = to_n;
      e.ical  = dac_if.dataical * iref / 640.0;
    end
    e.atb0 = vss;
    e.atb1 = vss;
    if (dac_if.atest_ena) begin
      case (dac_if.atb_ena)
        2'd1:    e.atb0 = vcas;
        2'd2:    begin e.atb0 = vdd08; e.atb1 = vdd18; end
        2'd3:    begin e.atb0 = vcas;  e.atb1 = vdd08 / 2.0; end
        default: ;
      endcase
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      check({e.name, ".iout"},  iout,  e.iout);
      check({e.name, ".ioutb"}, ioutb, e.ioutb);
      check({e.name, ".ical"},  ical,  e.ical);
      check({e.name, ".atb0"},  atb0,  e.atb0);
      check({e.name, ".atb1"},  atb1,  e.atb1);
    end
  end

  // Called just after a falling edge; inputs set beforehand are captured on the next rising
  // edge, and the monitor checks the outputs on the falling edge after that.
  task automatic apply(input string name);
    exp_t e;
    @(posedge clk);
    e = model();
    e.name = name;
    sb.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic set_codes(input logic [6:0] din, input logic [16:0] th, input logic [4:0] cal);
    dac_if.datain     = din;
    dac_if.datainb    = ~din;
    dac_if.datatherm  = th;
    dac_if.datathermb = ~th;
    dac_if.dataical   = cal;
  endtask

  task automatic nominal_currents();
    for (int i = 0; i < 17; i++) ith[i] = 500e-6 / 2.5;
    for (int k = 0; k < 6; k++)  ibin[k] = 500e-6 / (2.5 * real'(1 << (6 - k)));
    ired = 500e-6 / 160.0;
  endtask

  initial begin
    rst_n = 1'b0;
    iref  = 500e-6;
    vdd18 = 1.8;
    vdd08 = 0.8;
    vss   = 0.0;
    vcas  = 0.8;
    nominal_currents();
    dac_if.pdb       = 1'b1;
    dac_if.atest_ena = 1'b1;
    dac_if.atb_ena   = 2'd3;
    set_codes(7'h55, 17'h1FFFF, 5'd31);
    #1;
    apply("reset");

    rst_n = 1'b1;
    dac_if.pdb = 1'b0;
    set_codes(7'h55, 17'h0, 5'd17);
    apply("pdb_off");

    dac_if.pdb = 1'b1;
    set_codes(7'h00, 17'h0, 5'd0);
    apply("all_zero");
    set_codes(7'h7F, 17'h1FFFF, 5'd0);
    apply("all_one");

    for (int c = 0; c < 128; c++) begin
      set_codes(7'(c), 17'h0, 5'd0);
      apply($sformatf("bin%0d", c));
    end

    for (int i = 0; i <= 16; i++) begin
      set_codes(7'h00, 17'((1 << i) - 1), 5'd0);
      apply($sformatf("therm%0d", i));
    end
    set_codes(7'h00, 17'h1FFFF, 5'd0);
    dac_if.datathermb[0] = 1'b1;
    apply("therm_bad_pair");
    set_codes(7'h40, 17'h0, 5'd0);
    dac_if.datainb[6] = 1'b1;
    apply("red_bad_pair");

    for (int c = 0; c < 32; c++) begin
      set_codes(7'h2A, 17'h00F0F, 5'(c));
      apply($sformatf("ical%0d", c));
    end

    set_codes(7'h33, 17'h0FFFF, 5'd20);
    vdd18 = 1.70; apply("v18_low_out");
    vdd18 = 1.71; apply("v18_low_edge");
    vdd18 = 1.89; apply("v18_high_edge");
    vdd18 = 1.90; apply("v18_high_out");
    vdd18 = 1.8;
    vdd08 = 0.75; apply("v08_low_out");
    vdd08 = 0.76; apply("v08_low_edge");
    vdd08 = 0.84; apply("v08_high_edge");
    vdd08 = 0.85; apply("v08_high_out");
    vdd08 = 0.8;

    dac_if.atest_ena = 1'b1;
    for (int a = 0; a < 4; a++) begin
      dac_if.atb_ena = 2'(a);
      apply($sformatf("atb%0d", a));
    end
    dac_if.atest_ena = 1'b0;
    vss = 0.05;
    apply("atb_off");
    vss = 0.0;

    rst_n = 1'b0;
    apply("reset_mid");
    rst_n = 1'b1;
    apply("reset_reload");

    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < 17; i++) ith[i] = 200e-6 * (0.98 + 0.001 * $urandom_range(0, 40));
      for (int k = 0; k < 6; k++)  ibin[k] = (100e-6 / real'(1 << (5 - k))) * (0.98 + 0.001 * $urandom_range(0, 40));
      ired  = 3.125e-6 * (0.98 + 0.001 * $urandom_range(0, 40));
      iref  = 500e-6 * (0.95 + 0.001 * $urandom_range(0, 100));
      vdd18 = 1.65 + 0.001 * $urandom_range(0, 300);
      vdd08 = 0.72 + 0.001 * $urandom_range(0, 160);
      vcas  = 0.5 + 0.001 * $urandom_range(0, 500);
      dac_if.pdb       = ($urandom_range(0, 7) != 0);
      dac_if.atest_ena = $urandom_range(0, 1) != 0;
      dac_if.atb_ena   = 2'($urandom_range(0, 3));
      set_codes(7'($urandom), 17'($urandom), 5'($urandom));
      if ($urandom_range(0, 3) == 0) dac_if.datainb    = dac_if.datainb ^ 7'(1 << $urandom_range(0, 6));
      if ($urandom_range(0, 3) == 0) dac_if.datathermb = dac_if.datathermb ^ 17'(1 << $urandom_range(0, 16));
      apply($sformatf("rand%0d", n));
    end

    for (int w = 0; w < 5 && sb.size() != 0; w++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected results left unchecked, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
